// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed six-digit seven-segment scan controller
// with dead time, 16-level brightness PWM, per-digit blanking and a frame strobe.
// Optional build macro SEVEN_SEG_ACTIVE_LOW_EN inverts seg_o/dig_o (dark = all ones)
// for common-anode displays with PNP digit drivers; frame_o is unaffected.
module seven_seg_scan_ctrl #(
    parameter int unsigned PRESCALE = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [41:0] seven_seg_hms_i,
    input  logic [5:0]  digit_blank_i,
    input  logic [3:0]  brightness_i,
    output logic [6:0]  seg_o,
    output logic [5:0]  dig_o,
    output logic        frame_o
);

    localparam int unsigned    PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  P_LAST = PW'(PRESCALE - 1);

`ifdef SEVEN_SEG_ACTIVE_LOW_EN
    localparam logic ACTIVE_LOW = 1'b1;
`else
    localparam logic ACTIVE_LOW = 1'b0;
`endif

    localparam logic [6:0] SEG_DARK = {7{ACTIVE_LOW}};
    localparam logic [5:0] DIG_DARK = {6{ACTIVE_LOW}};

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [PW-1:0] p;
    logic [3:0]    t;
    logic [2:0]    d;
    logic [41:0]   snap;
    logic [5:0]    blank;
    logic [3:0]    bright;

    logic          tick_wrap;
    logic          slot_wrap;
    logic          frame_wrap;
    logic          lit;
    logic [6:0]    seg_sel;
    logic [5:0]    dig_sel;
    logic          blank_sel;

    // State register: enable_i alone decides IDLE vs SCAN each edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, counter wrap detection, current-digit mux and drive condition
    always_comb begin
        state_next = enable_i ? SCAN : IDLE;
        tick_wrap  = (p == P_LAST);
        slot_wrap  = tick_wrap && (t == 4'd15);
        frame_wrap = slot_wrap && (d == 3'd5);
        seg_sel    = '0;
        dig_sel    = '0;
        blank_sel  = 1'b1;
        case (d)
            3'd0: begin seg_sel = snap[6:0];   dig_sel = 6'b000001; blank_sel = blank[0]; end
            3'd1: begin seg_sel = snap[13:7];  dig_sel = 6'b000010; blank_sel = blank[1]; end
            3'd2: begin seg_sel = snap[20:14]; dig_sel = 6'b000100; blank_sel = blank[2]; end
            3'd3: begin seg_sel = snap[27:21]; dig_sel = 6'b001000; blank_sel = blank[3]; end
            3'd4: begin seg_sel = snap[34:28]; dig_sel = 6'b010000; blank_sel = blank[4]; end
            3'd5: begin seg_sel = snap[41:35]; dig_sel = 6'b100000; blank_sel = blank[5]; end
            default: ;
        endcase
        // Tick 0 of every slot is dead time; enable_i gates so a drop darkens on that edge
        lit = enable_i && (state == SCAN) && (t != 4'd0) && (t <= bright) && !blank_sel;
    end

    // Prescaler/tick/digit counters with slot-boundary brightness and frame-boundary snapshot loads
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p      <= '0;
            t      <= '0;
            d      <= '0;
            snap   <= '0;
            blank  <= '0;
            bright <= '0;
        end else if (state_next == IDLE) begin
            p <= '0;
            t <= '0;
            d <= '0;
        end else if (state == IDLE) begin
            p      <= '0;
            t      <= '0;
            d      <= '0;
            snap   <= seven_seg_hms_i;
            blank  <= digit_blank_i;
            bright <= brightness_i;
        end else begin
            p <= tick_wrap ? '0 : p + 1'b1;
            if (tick_wrap) begin
                t <= t + 4'd1;
            end
            if (slot_wrap) begin
                d      <= (d == 3'd5) ? 3'd0 : d + 3'd1;
                bright <= brightness_i;
            end
            if (frame_wrap) begin
                snap  <= seven_seg_hms_i;
                blank <= digit_blank_i;
            end
        end
    end

    // Registered output stage: one cycle after counter state, polarity applied here
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_o   <= SEG_DARK;
            dig_o   <= DIG_DARK;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= lit ? (seg_sel ^ SEG_DARK) : SEG_DARK;
            dig_o   <= lit ? (dig_sel ^ DIG_DARK) : DIG_DARK;
            frame_o <= enable_i && (state == SCAN) && frame_wrap;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl at PRESCALE=2: per-cycle scoreboard fed by an
// arithmetic position model, a table of brightness/blank frame vectors, and
// hand-written sequences for latency, frame period, snapshot, enable and reset.
module tb_seven_seg_scan_ctrl;

    localparam int P     = 2;
    localparam int SLOT  = 16 * P;
    localparam int FRAME = 6 * SLOT;

`ifdef SEVEN_SEG_ACTIVE_LOW_EN
    localparam logic AL = 1'b1;
`else
    localparam logic AL = 1'b0;
`endif
    localparam logic [6:0] SEG_DARK = {7{AL}};
    localparam logic [5:0] DIG_DARK = {6{AL}};

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [41:0] hms;
    logic [5:0]  blank;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic [5:0]  dig;
    logic        frame;

    int tests = 0;
    int fails = 0;

    seven_seg_scan_ctrl #(.PRESCALE(P)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .seven_seg_hms_i (hms),
        .digit_blank_i   (blank),
        .brightness_i    (brightness),
        .seg_o           (seg),
        .dig_o           (dig),
        .frame_o         (frame)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] dig_l();
        return dig ^ DIG_DARK;
    endfunction

    function automatic logic [6:0] seg_l();
        return seg ^ SEG_DARK;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- scoreboard: model pushes at posedge, compare pops at negedge
    logic [13:0] sbq[$];
    int          m;
    bit          act = 1'b0;
    logic [3:0]  mb;
    logic [41:0] ms;
    logic [5:0]  mbl;

    always @(posedge clk) begin
        logic [13:0] e;
        int          slot;
        int          tick;
        bit          lt;
        bit          fr;
        e = {1'b0, DIG_DARK, SEG_DARK};
        if (rst || !enable) begin
            act = 1'b0;
        end else if (!act) begin
            act = 1'b1;
            m   = 0;
            mb  = brightness;
            ms  = hms;
            mbl = blank;
        end else begin
            slot = (m / SLOT) % 6;
            tick = (m % SLOT) / P;
            lt   = (tick >= 1) && (tick <= int'(mb)) && !mbl[slot];
            fr   = ((m % FRAME) == FRAME - 1);
            if (lt) begin
                e[12:7] = 6'(1 << slot) ^ DIG_DARK;
                e[6:0]  = ms[7*slot +: 7] ^ SEG_DARK;
            end
            e[13] = fr;
            if ((m % SLOT) == SLOT - 1) mb = brightness;
            if (fr) begin
                ms  = hms;
                mbl = blank;
            end
            m++;
        end
        sbq.push_back(e);
    end

    always @(negedge clk) begin
        logic [13:0] e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (rst) e = {1'b0, DIG_DARK, SEG_DARK};
            tests++;
            if ({frame, dig, seg} !== e) begin
                fails++;
                $display("FAIL scoreboard at %0t: got frame=%b dig=%b seg=%h, expected frame=%b dig=%b seg=%h",
                         $time, frame, dig, seg, e[13], e[12:7], e[6:0]);
            end
        end
    end

    // ---------------- helpers
    task automatic wait_dig(input logic [5:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (dig_l() == target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_dig_timeout", 0, 1);
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (frame) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_frame_timeout", 0, 1);
    endtask

    task automatic count_lit(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (dig_l() != 6'd0) c++;
        end
    endtask

    task automatic latency(input string name);
        int k;
        k = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            k++;
            if (dig_l() == 6'b000001) break;
        end
        // entry edge N, first lit after edge N+PRESCALE+1
        check(name, k, P + 2);
    endtask

    typedef struct {
        logic [3:0] bright;
        logic [5:0] blank;
        int         exp_lit;
    } vec_t;

    vec_t        vecs[6];
    logic [41:0] pat_old;
    logic [41:0] pat_new;

    initial begin
        bit ok;
        int c;
        int n;

        vecs[0] = '{4'd15, 6'b000000, 180};
        vecs[1] = '{4'd0,  6'b000000, 0};
        vecs[2] = '{4'd4,  6'b000000, 48};
        vecs[3] = '{4'd15, 6'b100000, 150};
        vecs[4] = '{4'd1,  6'b010101, 6};
        vecs[5] = '{4'd8,  6'b000001, 80};

        for (int k = 0; k < 6; k++) begin
            pat_old[7*k +: 7] = 7'(7'h01 << k);
            pat_new[7*k +: 7] = 7'(7'h40 >> k) | 7'h01;
        end

        rst        = 1'b1;
        enable     = 1'b0;
        hms        = pat_old;
        blank      = '0;
        brightness = 4'd15;
        repeat (3) @(negedge clk);
        check("reset_seg", int'(seg), int'(SEG_DARK));
        check("reset_dig", int'(dig), int'(DIG_DARK));
        check("reset_frame", int'(frame), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_dig", int'(dig), int'(DIG_DARK));

        // first lit digit after enable
        enable = 1'b1;
        latency("first_lit_latency");
        check("first_lit_seg", int'(seg_l()), 1);

        // frame strobe period
        wait_frame(ok);
        n = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n++;
            if (frame) break;
        end
        check("frame_period", n, FRAME);

        // table: full-frame lit-cycle counts
        for (int v = 0; v < 6; v++) begin
            brightness = vecs[v].bright;
            blank      = vecs[v].blank;
            wait_frame(ok);
            count_lit(FRAME, c);
            check($sformatf("frame_lit_v%0d", v), c, vecs[v].exp_lit);
        end

        // brightness change mid-slot: current slot keeps old value
        brightness = 4'd15;
        blank      = '0;
        wait_frame(ok);
        brightness = 4'd4;
        wait_frame(ok);
        count_lit(SLOT / 2, c);
        brightness = 4'd15;
        count_lit(SLOT / 2, n);
        check("bright_slot_old", c + n, 8);
        count_lit(SLOT, c);
        check("bright_slot_new", c, 30);

        // snapshot: new data during digit 2 appears only next frame
        wait_dig(6'b000100, ok);
        hms = pat_new;
        wait_dig(6'b001000, ok);
        check("snap_old_d3", int'(seg_l()), int'(pat_old[27:21]));
        wait_dig(6'b100000, ok);
        check("snap_old_d5", int'(seg_l()), int'(pat_old[41:35]));
        wait_frame(ok);
        wait_dig(6'b000001, ok);
        check("snap_new_d0", int'(seg_l()), int'(pat_new[6:0]));

        // blank mask mid-frame: only the following frame changes
        wait_dig(6'b000010, ok);
        blank = 6'b100000;
        wait_dig(6'b100000, ok);
        check("blank_late_still_lit", int'(dig_l()), 32);
        wait_frame(ok);
        count_lit(FRAME, c);
        check("blank_d5_frame", c, 150);
        blank = '0;

        // enable drop during digit 3 lit window
        wait_dig(6'b001000, ok);
        enable = 1'b0;
        @(negedge clk);
        check("disable_dig", int'(dig), int'(DIG_DARK));
        check("disable_seg", int'(seg), int'(SEG_DARK));
        repeat (4) @(negedge clk);
        enable = 1'b1;
        latency("reenable_latency");

        // asynchronous reset mid-slot
        wait_dig(6'b000010, ok);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_dig", int'(dig), int'(DIG_DARK));
        check("async_rst_seg", int'(seg), int'(SEG_DARK));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        latency("post_reset_latency");
        repeat (FRAME + 20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for the six-digit HH:MM:SS seven-segment display. It takes the 42-bit segment vector produced by the HMS segment decoder and drives one shared 7-bit segment bus plus six digit enables, one digit at a time. It also provides anti-ghosting dead time, 16-level brightness PWM, per-digit blanking and a frame strobe. It sits between the segment decoder and the chip output pins.

## Interface
- `PRESCALE`, default 64: clock cycles per tick; legal range ≥1. One slot is 16 ticks; one frame is 6 slots.
- `clk_i`  in  1  system clock
- `rst_i`  in  1  reset; asynchronous, active-high
- `enable_i`  in  1  high = scan; low = display dark and counters cleared
- `seven_seg_hms_i`  in  42  digit k pattern at [7k +: 7]; k=0 is seconds-low, k=5 is hours-high
- `digit_blank_i`  in  6  bit k set = digit k dark for the whole frame (e.g. leading-zero hours)
- `brightness_i`  in  4  on-ticks per slot; 0 = dark, 15 = maximum
- `seg_o`  out  7  shared segment bus, registered
- `dig_o`  out  6  one-hot digit enable, registered; all-zero when no digit is lit
- `frame_o`  out  1  one-cycle pulse, registered

## Operation
- Two states: IDLE and SCAN.
- **IDLE** (after reset, or whenever `enable_i`=0):
  - counters held at 0: prescaler p, tick t, digit d.
  - `seg_o`, `dig_o` and `frame_o` driven to 0 on the next edge.
- **IDLE→SCAN**, on the first edge with `enable_i`=1:
  - p=t=d=0.
  - Snapshot registers load `seven_seg_hms_i` and `digit_blank_i`.
  - Brightness register loads `brightness_i`.
- **SCAN→IDLE**, on any edge with `enable_i`=0, including mid-slot: counters clear and outputs go to 0 on that edge.
- Counting in SCAN:
  - p increments every cycle. At p=PRESCALE-1, p←0 and t increments.
  - At t=15 with p wrapping, t←0 and d increments.
  - At d=5 with t and p wrapping, d←0.
- Brightness register reloads from `brightness_i` whenever t wraps to 0. Brightness is therefore constant within a slot.
- Snapshot registers reload whenever d wraps 5→0. Digit data is therefore constant within a frame, so there is no tearing.
- Drive condition: lit = SCAN AND t≥1 AND t≤brightness AND NOT blank[d]. Tick 0 of every slot is dead time.
- Outputs on the next edge:
  - if lit: `dig_o` = 1<<d, `seg_o` = snapshot[7d +: 7].
  - otherwise: `dig_o` = 0, `seg_o` = 0.
- `frame_o`=1 for exactly the one cycle after the edge on which d wraps 5→0. It does not pulse on IDLE→SCAN entry.

## Timing
- Output latency: one cycle from counter state. Worst-case path: compare plus 6:1 mux of 7 bits.
- Let IDLE→SCAN occur at edge N. The first `dig_o`=000001 appears after edge N+PRESCALE+1.
- Per slot, digit on-time is brightness×PRESCALE cycles.
- Slot length is 16×PRESCALE cycles; frame length is 96×PRESCALE cycles.
- `frame_o` period is 96×PRESCALE cycles.
- PRESCALE=1 is legal: t advances every cycle.
- Changes to inputs between snapshot loads have no visible effect until the next frame. Brightness changes take effect at the next slot boundary.
- `rst_i` asserted at any time: all registers and outputs take their reset value immediately, without waiting for a clock. After deassertion the block is in IDLE.
- Reset values: `seg_o`=0, `dig_o`=0, `frame_o`=0. With `SEVEN_SEG_ACTIVE_LOW_EN`, `seg_o`=7'h7F and `dig_o`=6'h3F.

## Configuration
- Macro: `SEVEN_SEG_ACTIVE_LOW_EN`.
- Defined: `seg_o` and `dig_o` are inverted at the output registers, for common-anode displays with PNP digit drivers. "Dark" and reset become all-ones. `frame_o` is unaffected.
- Undefined: active-high outputs as described above.

## Test plan
- **Basic scan.** Setup: PRESCALE=2, brightness=15, no blanking, digit k pattern = 7'h01<<k. Assert enable.
  - `dig_o` steps through 000001…100000.
  - Each digit is lit for 30 cycles, followed by 2 dark cycles.
  - `seg_o` matches the pattern while lit.
  - `frame_o` pulses every 192 cycles.
- **Brightness.** brightness=0: `dig_o` stays 0 forever. brightness=4: 8 lit cycles per 32-cycle slot. Change brightness 4→15 mid-slot: the current slot stays at 8 lit cycles and the next slot has 30.
- **Blanking.** `digit_blank_i`=6'b100000: digit 5 slot fully dark, other digits unchanged. Change the mask mid-frame: takes effect only after the next `frame_o`.
- **Snapshot.** Change `seven_seg_hms_i` during the digit 2 slot: digits 3–5 still show the old data, and the new data appears from the digit 0 slot after the wrap.
- **Enable/reset mid-operation.**
  - Drop `enable_i` during the digit 3 lit window: outputs are 0 after the next edge, and re-enabling restarts at digit 0 with dead time.
  - Assert `rst_i` asynchronously mid-slot: outputs clear before the next clock edge.
- **Macro.** Rerun basic scan with `SEVEN_SEG_ACTIVE_LOW_EN` defined: the exact bitwise complement of `seg_o` and `dig_o`, and 7'h7F / 6'h3F in reset.
